// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage and its neighbours: the instruction
// memory, the branch predictor, the ROB redirect and the decoder.
interface fetch_unit_if;
    logic        icache_req_valid;
    logic [29:0] icache_req_addr;
    logic        icache_req_ready;
    logic        icache_resp_valid;
    logic        icache_resp_error;
    logic [31:0] icache_resp_insn;
    logic [29:0] fetch_bp_addr;
    logic        bp_taken;
    logic [30:0] bp_target;
    logic [15:0] bp_tag;
    logic        rob_flush;
    logic [30:0] rob_flush_target;
    logic        decode_stall;
    logic        fetch_de_valid;
    logic        fetch_de_error;
    logic [30:0] fetch_de_addr;
    logic [31:0] fetch_de_insn;
    logic [15:0] fetch_de_bptag;
    logic        fetch_de_bptaken;

    modport master (
        output icache_req_valid, icache_req_addr, fetch_bp_addr,
        output fetch_de_valid, fetch_de_error, fetch_de_addr,
        output fetch_de_insn, fetch_de_bptag, fetch_de_bptaken,
        input  icache_req_ready, icache_resp_valid, icache_resp_error, icache_resp_insn,
        input  bp_taken, bp_target, bp_tag, rob_flush, rob_flush_target, decode_stall
    );

    modport slave (
        input  icache_req_valid, icache_req_addr, fetch_bp_addr,
        input  fetch_de_valid, fetch_de_error, fetch_de_addr,
        input  fetch_de_insn, fetch_de_bptag, fetch_de_bptaken,
        output icache_req_ready, icache_resp_valid, icache_resp_error, icache_resp_insn,
        output bp_taken, bp_target, bp_tag, rob_flush, rob_flush_target, decode_stall
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: walks the PC along predicted paths, issues word
// requests, pairs in-order responses with their predictor metadata and
// buffers finished entries for decode. A fault or misaligned PC halts
// fetch until the ROB redirects.
//
// state | meaning
// RUN   | fetching along the predicted path
// HALT  | fault seen; only draining buffered entries, waiting for rob_flush
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // Responses from several back-to-back flushes can pile up beyond DEPTH,
    // so the drop counter is sized for memory latency rather than DEPTH.
    localparam int DW = 16;

    typedef enum logic {RUN, HALT} state_t;

    typedef struct packed {
        logic [30:0] addr;
        logic [15:0] bptag;
        logic        bptaken;
    } meta_t;

    typedef struct packed {
        logic        error;
        logic [30:0] addr;
        logic [31:0] insn;
        logic [15:0] bptag;
        logic        bptaken;
    } entry_t;

    state_t        state_q, state_d;
    logic [31:1]   pc_q, pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [DW-1:0] drop_q, drop_d;
    meta_t         meta_mem_q [DEPTH];
    meta_t         meta_mem_d [DEPTH];
    logic [AW-1:0] meta_wr_q, meta_wr_d, meta_rd_q, meta_rd_d;
    entry_t        out_mem_q [DEPTH];
    entry_t        out_mem_d [DEPTH];
    logic [AW-1:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;

    logic   credit, req_valid, req_fire, misalign;
    logic   resp_take, resp_drop, out_valid, out_pop, out_push;
    entry_t out_entry, head;
    meta_t  meta_head;

    // Credit counts are taken before this cycle's pop so a returning response always finds room.
    assign credit    = ({1'b0, inflight_q} + {1'b0, out_cnt_q}) < (CW+1)'(DEPTH);
    assign req_valid = (state_q == RUN) & ~pc_q[1] & credit & ~bus.rob_flush & ~rst;
    assign req_fire  = req_valid & bus.icache_req_ready;
    assign resp_take = bus.icache_resp_valid & ~bus.rob_flush & (drop_q == '0);
    assign resp_drop = bus.icache_resp_valid & ~bus.rob_flush & (drop_q != '0);
    assign misalign  = (state_q == RUN) & pc_q[1] & (inflight_q == '0) & credit
                       & ~bus.rob_flush & ~resp_take;
    assign out_valid = out_cnt_q != '0;
    assign out_pop   = out_valid & ~bus.decode_stall;
    assign meta_head = meta_mem_q[meta_rd_q];
    assign head      = out_mem_q[out_rd_q];

    assign bus.icache_req_valid = req_valid;
    assign bus.icache_req_addr  = pc_q[31:2];
    assign bus.fetch_bp_addr    = pc_q[31:2];
    assign bus.fetch_de_valid   = out_valid;
    assign bus.fetch_de_error   = out_valid & head.error;
    assign bus.fetch_de_addr    = out_valid ? head.addr : '0;
    assign bus.fetch_de_insn    = out_valid ? head.insn : '0;
    assign bus.fetch_de_bptag   = out_valid ? head.bptag : '0;
    assign bus.fetch_de_bptaken = out_valid & head.bptaken;

    // Next-state: redirect, request issue, response pairing and queue bookkeeping.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        meta_mem_d = meta_mem_q;
        meta_wr_d  = meta_wr_q;
        meta_rd_d  = meta_rd_q;
        out_mem_d  = out_mem_q;
        out_wr_d   = out_wr_q;
        out_rd_d   = out_rd_q;
        out_cnt_d  = out_cnt_q;
        out_push   = 1'b0;
        out_entry  = '0;

        if (bus.rob_flush) begin
            pc_d       = bus.rob_flush_target;
            state_d    = RUN;
            drop_d     = drop_q + DW'(inflight_q) - DW'(bus.icache_resp_valid);
            inflight_d = '0;
            meta_wr_d  = '0;
            meta_rd_d  = '0;
            out_wr_d   = '0;
            out_rd_d   = '0;
            out_cnt_d  = '0;
        end else begin
            inflight_d = inflight_q + CW'(req_fire) - CW'(resp_take);

            if (req_fire) begin
                meta_mem_d[meta_wr_q] = '{addr: pc_q, bptag: bus.bp_tag, bptaken: bus.bp_taken};
                meta_wr_d = meta_wr_q + AW'(1);
                pc_d = bus.bp_taken ? bus.bp_target : {pc_q[31:2] + 30'd1, 1'b0};
            end

            if (misalign) begin
                out_push  = 1'b1;
                out_entry = '{error: 1'b1, addr: pc_q, insn: '0, bptag: '0, bptaken: 1'b0};
                state_d   = HALT;
            end

            if (resp_drop) begin
                drop_d = drop_q - DW'(1);
            end else if (resp_take) begin
                out_push  = 1'b1;
                out_entry = '{error: bus.icache_resp_error, addr: meta_head.addr,
                              insn: bus.icache_resp_error ? 32'h0 : bus.icache_resp_insn,
                              bptag: meta_head.bptag, bptaken: meta_head.bptaken};
                meta_rd_d = meta_rd_q + AW'(1);
                if (bus.icache_resp_error) begin
                    // Everything younger than the fault, including a request
                    // accepted this very cycle, is still owed by memory.
                    state_d    = HALT;
                    drop_d     = DW'(inflight_q) - DW'(1) + DW'(req_fire);
                    inflight_d = '0;
                    meta_wr_d  = '0;
                    meta_rd_d  = '0;
                end
            end

            if (out_pop) begin
                out_rd_d = out_rd_q + AW'(1);
            end
            if (out_push) begin
                out_mem_d[out_wr_q] = out_entry;
                out_wr_d = out_wr_q + AW'(1);
            end
            out_cnt_d = out_cnt_q + CW'(out_push) - CW'(out_pop);
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC[31:1];
            inflight_q <= '0;
            drop_q     <= '0;
            meta_wr_q  <= '0;
            meta_rd_q  <= '0;
            out_wr_q   <= '0;
            out_rd_q   <= '0;
            out_cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                meta_mem_q[i] <= '0;
                out_mem_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            meta_wr_q  <= meta_wr_d;
            meta_rd_q  <= meta_rd_d;
            out_wr_q   <= out_wr_d;
            out_rd_q   <= out_rd_d;
            out_cnt_q  <= out_cnt_d;
            meta_mem_q <= meta_mem_d;
            out_mem_q  <= out_mem_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit. The reference model works at path level: after a
// redirect, the decoder must see exactly the predicted-path entries up to
// and including the first fault or misaligned PC, independent of timing.
module tb_fetch_unit;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic        err;
        logic [30:0] addr;
        logic [31:0] insn;
        logic [15:0] tag;
        logic        tk;
    } ent_t;

    typedef struct {
        logic [29:0] w;
        int          rdy;
    } mreq_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0100), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ent_t        exp_q[$];
    logic [29:0] req_q[$];
    mreq_t       mq[$];
    int          pop_cyc[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_rdy = -1;
    int          acc_n = 0;
    int          pop_n = 0;
    bit          halted_seen = 0;
    bit          prev_flush = 0;
    logic        last_req_valid;
    logic [29:0] bp_w[4];
    logic [31:0] bp_t[4];
    logic [15:0] bp_g[4];
    int          bp_n = 0;
    logic [29:0] flt_w[4];
    int          flt_n = 0;
    logic [15:0] salt;
    int          stall_mode = 0;
    int          ready_mode = 0;
    int          lat_min = 1;
    int          lat_max = 1;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] insn_of(input logic [29:0] w);
        return {w[15:0], ~w[15:0]} ^ 32'h5a5a_1234;
    endfunction

    function automatic bit is_fault(input logic [29:0] w);
        for (int i = 0; i < flt_n; i++) if (flt_w[i] == w) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int bp_idx(input logic [29:0] w);
        for (int i = 0; i < bp_n; i++) if (bp_w[i] == w) return i;
        return -1;
    endfunction

    function automatic logic [15:0] tag_of(input logic [29:0] w);
        int k;
        k = bp_idx(w);
        return (k >= 0) ? bp_g[k] : (w[15:0] ^ salt);
    endfunction

    // Expected decode stream and request stream from redirect address t.
    function automatic void build(input logic [31:0] t);
        logic [31:0] p;
        logic [29:0] w;
        bit          stop_e;
        bit          f;
        int          k;
        ent_t        e;
        exp_q.delete();
        req_q.delete();
        p = t;
        stop_e = 0;
        for (int n = 0; n < 200; n++) begin
            if (p[1]) begin
                if (!stop_e) begin
                    e = '{err: 1'b1, addr: p[31:1], insn: 32'h0, tag: 16'h0, tk: 1'b0};
                    exp_q.push_back(e);
                end
                break;
            end
            w = p[31:2];
            k = bp_idx(w);
            req_q.push_back(w);
            if (!stop_e) begin
                f = is_fault(w);
                e = '{err: f, addr: p[31:1], insn: f ? 32'h0 : insn_of(w),
                      tag: tag_of(w), tk: (k >= 0)};
                exp_q.push_back(e);
                if (f) stop_e = 1;
            end
            p = (k >= 0) ? bp_t[k] : {p[31:2] + 30'd1, 2'b00};
        end
    endfunction

    // One clock: drive inputs, sample and score outputs, advance.
    task automatic step(input bit fl, input logic [31:0] ft);
        logic [29:0] w;
        int          k;
        int          lat;
        int          rdy;
        ent_t        e;
        mreq_t       m;

        w = bus.fetch_bp_addr;
        k = bp_idx(w);
        bus.bp_taken  = (k >= 0);
        bus.bp_target = (k >= 0) ? bp_t[k][31:1] : 31'($urandom);
        bus.bp_tag    = tag_of(w);

        if (mq.size() > 0 && mq[0].rdy <= cyc) begin
            m = mq.pop_front();
            bus.icache_resp_valid = 1'b1;
            bus.icache_resp_error = is_fault(m.w);
            bus.icache_resp_insn  = insn_of(m.w);
        end else begin
            bus.icache_resp_valid = 1'b0;
            bus.icache_resp_error = 1'($urandom);
            bus.icache_resp_insn  = $urandom;
        end
        bus.icache_req_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        bus.decode_stall     = (stall_mode == 0) ? 1'b0 :
                               (stall_mode == 1) ? 1'b1 : ($urandom_range(0, 2) == 0);
        bus.rob_flush        = fl;
        bus.rob_flush_target = ft[31:1];
        #1;

        last_req_valid = bus.icache_req_valid;
        if (prev_flush) check("flush_clears_valid", bus.fetch_de_valid, 1'b0);
        if (!bus.fetch_de_valid)
            check("empty_fields_zero", {bus.fetch_de_error, bus.fetch_de_addr, bus.fetch_de_insn,
                                        bus.fetch_de_bptag, bus.fetch_de_bptaken}, '0);
        if (fl) check("flush_no_req", bus.icache_req_valid, 1'b0);
        if (halted_seen) check("halt_no_req", bus.icache_req_valid, 1'b0);

        if (bus.fetch_de_valid && !bus.decode_stall) begin
            if (exp_q.size() == 0) begin
                check("de_extra_entry", bus.fetch_de_valid & ~bus.decode_stall, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("de_entry", {bus.fetch_de_error, bus.fetch_de_addr, bus.fetch_de_insn,
                                   bus.fetch_de_bptag, bus.fetch_de_bptaken}, e);
                if (e.err) halted_seen = 1;
            end
            pop_n++;
            pop_cyc.push_back(cyc);
        end

        if (bus.icache_req_valid && bus.icache_req_ready) begin
            if (req_q.size() == 0) begin
                check("req_extra", bus.icache_req_valid & bus.icache_req_ready, 1'b0);
            end else begin
                check("req_addr", bus.icache_req_addr, req_q.pop_front());
            end
            lat = $urandom_range(lat_min, lat_max);
            rdy = (cyc + lat > last_rdy + 1) ? cyc + lat : last_rdy + 1;
            last_rdy = rdy;
            m.w = bus.icache_req_addr;
            m.rdy = rdy;
            mq.push_back(m);
            acc_n++;
            check("credit_bound", (acc_n - pop_n) <= DEPTH, 1'b1);
        end

        if (fl) begin
            build(ft);
            acc_n = 0;
            pop_n = 0;
            halted_seen = 0;
        end
        prev_flush = fl;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        logic [31:0] t;

        rst = 1'b1;
        bus.icache_req_ready  = 1'b0;
        bus.icache_resp_valid = 1'b0;
        bus.icache_resp_error = 1'b0;
        bus.icache_resp_insn  = '0;
        bus.bp_taken          = 1'b0;
        bus.bp_target         = '0;
        bus.bp_tag            = '0;
        bus.rob_flush         = 1'b0;
        bus.rob_flush_target  = '0;
        bus.decode_stall      = 1'b0;
        salt = 16'($urandom);
        build(32'h0000_0100);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_valid", bus.icache_req_valid, 1'b0);
        check("rst_de_valid", bus.fetch_de_valid, 1'b0);
        check("rst_de_fields", {bus.fetch_de_error, bus.fetch_de_addr, bus.fetch_de_insn,
                                bus.fetch_de_bptag, bus.fetch_de_bptaken}, '0);
        check("rst_req_addr", bus.icache_req_addr, 30'h40);
        rst = 1'b0;

        // Straight-line fetch, 1-cycle memory, no stall
        pop_cyc.delete();
        repeat (10) step(1'b0, 32'h0);
        check("seq_pop_count", pop_cyc.size() >= 3, 1'b1);
        if (pop_cyc.size() >= 3) begin
            check("seq_consec_1", pop_cyc[1] - pop_cyc[0], 1);
            check("seq_consec_2", pop_cyc[2] - pop_cyc[1], 1);
        end

        // Backpressure: six stalled cycles fill the credit window
        stall_mode = 1;
        repeat (6) step(1'b0, 32'h0);
        check("stall_req_blocked", last_req_valid, 1'b0);
        stall_mode = 2; ready_mode = 1; lat_max = 3;
        repeat (25) step(1'b0, 32'h0);

        // Taken prediction at 0x200 -> 0x300
        bp_n = 1; bp_w[0] = 30'h80; bp_t[0] = 32'h0000_0300; bp_g[0] = 16'hBEEF;
        step(1'b1, 32'h0000_0200);
        repeat (25) step(1'b0, 32'h0);

        // Flush with three requests outstanding
        bp_n = 0; stall_mode = 0; ready_mode = 0; lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && mq.size() < 3; i++) step(1'b0, 32'h0);
        check("flush_outstanding", mq.size() >= 3, 1'b1);
        step(1'b1, 32'h0000_0400);
        lat_min = 1;
        repeat (20) step(1'b0, 32'h0);

        // Fault on 0x108
        flt_n = 1; flt_w[0] = 30'h42; stall_mode = 2; ready_mode = 1; lat_max = 3;
        step(1'b1, 32'h0000_0100);
        repeat (40) step(1'b0, 32'h0);
        check("fault_drained", exp_q.size(), 0);
        check("fault_halted", halted_seen, 1'b1);

        // Misaligned redirect
        flt_n = 0;
        step(1'b1, 32'h0000_0502);
        repeat (15) step(1'b0, 32'h0);
        check("misalign_drained", exp_q.size(), 0);
        check("misalign_halted", halted_seen, 1'b1);
        check("misalign_no_req", acc_n, 0);

        // Randomised paths, predictions, faults and timing
        for (int r = 0; r < 8; r++) begin
            t = 32'h0000_1000 + (32'($urandom_range(0, 1023)) << 2);
            if ($urandom_range(0, 4) == 0) t[1] = 1'b1;
            bp_n = $urandom_range(0, 2);
            for (int i = 0; i < bp_n; i++) begin
                bp_w[i] = t[31:2] + 30'($urandom_range(1, 6));
                bp_t[i] = 32'h0000_1000 + (32'($urandom_range(0, 1023)) << 2);
                if ($urandom_range(0, 7) == 0) bp_t[i][1] = 1'b1;
                bp_g[i] = 16'($urandom);
            end
            flt_n = $urandom_range(0, 1);
            flt_w[0] = t[31:2] + 30'($urandom_range(2, 10));
            stall_mode = $urandom_range(0, 2);
            ready_mode = $urandom_range(0, 1);
            lat_max = $urandom_range(1, 4);
            step(1'b1, t);
            repeat ($urandom_range(20, 50)) step(1'b0, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
